// File: rtl/ninjin_ddr_sched.sv
// Purpose: splits one read and one write DMA command into AXI-legal bursts (<=BURST_MAX beats, no 4KB crossing), round-robin between them.
// Latency: x_req -> ddr_req 2 cycles; ddr_done -> next ddr_req 2 cycles; final ddr_done -> x_done 1 cycle.
// Backpressure: a slot holds one command; x_req is ignored while x_busy; one burst outstanding, next issued only after ddr_done.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   rd_req/rd_base/rd_total          read command (host->ram): strobe, byte base, beat count
//   rd_busy/rd_done/rd_err           read slot held, completion pulse, aborted flag (valid with rd_done)
//   wr_*                             same for the write command (ram->host)
//   ddr_req/ddr_mode/ddr_base/ddr_len  burst issue to the DMA engine; mode/base/len held until ddr_done
//   ddr_done/ddr_err                 burst completion pulse and error code from the DMA engine
//   err                              sticky error, first one wins, cleared only by rst
module ninjin_ddr_sched #(
  parameter int BURST_MAX = 256,
  parameter int TWIDTH    = 24,
  parameter int BWIDTH    = 32,
  parameter int MEMSIZE   = 30,
  parameter int LWIDTH    = 9
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rd_req,
  input  logic [MEMSIZE+$clog2(BWIDTH/8)-1:0] rd_base,
  input  logic [TWIDTH-1:0]                  rd_total,
  output logic                               rd_busy,
  output logic                               rd_done,
  output logic                               rd_err,
  input  logic                               wr_req,
  input  logic [MEMSIZE+$clog2(BWIDTH/8)-1:0] wr_base,
  input  logic [TWIDTH-1:0]                  wr_total,
  output logic                               wr_busy,
  output logic                               wr_done,
  output logic                               wr_err,
  output logic                               ddr_req,
  output logic                               ddr_mode,
  output logic [MEMSIZE+$clog2(BWIDTH/8)-1:0] ddr_base,
  output logic [LWIDTH-1:0]                  ddr_len,
  input  logic                               ddr_done,
  input  logic [3:0]                         ddr_err,
  output logic [3:0]                         err
);

  localparam int LSB = $clog2(BWIDTH/8);
  localparam int AW  = MEMSIZE + LSB;
  localparam logic DDR_READ  = 1'b0;
  localparam logic DDR_WRITE = 1'b1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [TWIDTH-1:0] BMAX_T = TWIDTH'(BURST_MAX);

  // Slot index 0 is the read command, 1 the write command.
  logic [1:0]        state;
  logic [1:0]        busy, done_q, xerr_q;
  logic [AW-1:0]     base_q [2];
  logic [TWIDTH-1:0] rem_q  [2];
  logic              last_grant;
  logic              gnt;

  logic [1:0]        req_v, misalign_v;
  logic [AW-1:0]     base_in [2];
  logic [TWIDTH-1:0] total_in [2];
  logic [1:0]        pend;
  logic              gnt_c;
  logic [AW-1:0]     gbase;
  logic [12:0]       room_bytes;
  logic [TWIDTH-1:0] room, len_c;
  logic [3:0]        err_nxt;

  always_comb begin
    req_v       = {wr_req, rd_req};
    base_in[0]  = rd_base;
    base_in[1]  = wr_base;
    total_in[0] = rd_total;
    total_in[1] = wr_total;
    for (int s = 0; s < 2; s++) begin
      misalign_v[s] = req_v[s] && !busy[s] && (base_in[s][LSB-1:0] != '0);
      pend[s]       = busy[s] && (rem_q[s] != '0);
    end
  end

  // Round-robin only matters when both slots are pending.
  always_comb begin
    gnt_c = 1'b0;
    if (pend == 2'b11) gnt_c = ~last_grant;
    else if (pend[1])  gnt_c = 1'b1;
  end

  // Burst length: min(remaining, BURST_MAX, beats left in this 4KB page).
  always_comb begin
    gbase      = base_q[gnt_c];
    room_bytes = 13'd4096 - {1'b0, gbase[11:0]};
    room       = TWIDTH'(room_bytes >> LSB);
    len_c      = rem_q[gnt_c];
    if (len_c > BMAX_T) len_c = BMAX_T;
    if (len_c > room)   len_c = room;
  end

  // First error sticks; a DMA error in the same cycle as a misaligned request takes priority.
  always_comb begin
    err_nxt = err;
    if (err == 4'd0) begin
      if (state == S_WAIT && ddr_done && ddr_err != 4'd0) err_nxt = {ddr_err[3:1], 1'b1};
      else if (misalign_v != 2'b00)                         err_nxt = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= '0;
      done_q     <= '0;
      xerr_q     <= '0;
      base_q[0]  <= '0;
      base_q[1]  <= '0;
      rem_q[0]   <= '0;
      rem_q[1]   <= '0;
      last_grant <= DDR_WRITE;
      gnt        <= 1'b0;
      ddr_mode   <= 1'b0;
      ddr_base   <= '0;
      ddr_len    <= '0;
      err        <= '0;
    end else begin
      done_q <= '0;
      xerr_q <= '0;
      err    <= err_nxt;

      // Accepting a command needs !busy and completing one needs busy, so they never collide.
      for (int s = 0; s < 2; s++) begin
        if (req_v[s] && !busy[s]) begin
          if (misalign_v[s]) begin
            done_q[s] <= 1'b1;
            xerr_q[s] <= 1'b1;
          end else if (total_in[s] == '0) begin
            done_q[s] <= 1'b1;
          end else begin
            busy[s]   <= 1'b1;
            base_q[s] <= base_in[s];
            rem_q[s]  <= total_in[s];
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (pend != 2'b00) begin
            gnt        <= gnt_c;
            last_grant <= gnt_c;
            ddr_mode   <= gnt_c ? DDR_WRITE : DDR_READ;
            ddr_base   <= gbase;
            ddr_len    <= LWIDTH'(len_c);
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (ddr_done) begin
            state <= S_IDLE;
            if (ddr_err != 4'd0) begin
              busy[gnt]   <= 1'b0;
              rem_q[gnt]  <= '0;
              done_q[gnt] <= 1'b1;
              xerr_q[gnt] <= 1'b1;
            end else begin
              base_q[gnt] <= base_q[gnt] + (AW'(ddr_len) << LSB);
              rem_q[gnt]  <= rem_q[gnt] - TWIDTH'(ddr_len);
              if (rem_q[gnt] == TWIDTH'(ddr_len)) begin
                busy[gnt]   <= 1'b0;
                done_q[gnt] <= 1'b1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ddr_req = (state == S_ISSUE);
  assign rd_busy = busy[0];
  assign wr_busy = busy[1];
  assign rd_done = done_q[0];
  assign wr_done = done_q[1];
  assign rd_err  = xerr_q[0];
  assign wr_err  = xerr_q[1];

endmodule

// File: tb/tb_ninjin_ddr_sched.sv
module tb_ninjin_ddr_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req;
  logic [31:0] rd_base, wr_base;
  logic [23:0] rd_total, wr_total;
  logic        rd_busy, rd_done, rd_err, wr_busy, wr_done, wr_err;
  logic        ddr_req, ddr_mode;
  logic [31:0] ddr_base;
  logic [8:0]  ddr_len;
  logic        ddr_done;
  logic [3:0]  ddr_err;
  logic [3:0]  err;

  int tests = 0;
  int fails = 0;
  int n_rd_done = 0, n_wr_done = 0, n_req = 0, consec = 0;
  int rec_req, rec_rd, rec_wr;
  logic prev_req = 1'b0;

  always #5 clk = ~clk;

  ninjin_ddr_sched dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_base(rd_base), .rd_total(rd_total),
    .rd_busy(rd_busy), .rd_done(rd_done), .rd_err(rd_err),
    .wr_req(wr_req), .wr_base(wr_base), .wr_total(wr_total),
    .wr_busy(wr_busy), .wr_done(wr_done), .wr_err(wr_err),
    .ddr_req(ddr_req), .ddr_mode(ddr_mode), .ddr_base(ddr_base), .ddr_len(ddr_len),
    .ddr_done(ddr_done), .ddr_err(ddr_err), .err(err)
  );

  // Event counters: read at posedge, i.e. the values of the cycle just ending.
  always @(posedge clk) begin
    if (rd_done) n_rd_done++;
    if (wr_done) n_wr_done++;
    if (ddr_req) begin
      n_req++;
      if (prev_req) consec++;
    end
    prev_req = ddr_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (ddr_req !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_req"}, {31'd0, ddr_req}, 32'd1);
  endtask

  // Wait for a burst, check it, then answer with ddr_done after dly cycles.
  // Returns on the negedge right after ddr_done was sampled.
  task automatic expect_burst(input string tag, input logic mode, input logic [31:0] base,
                              input int len, input logic [3:0] e, input int dly);
    wait_req(tag);
    chk({tag, "_mode"}, {31'd0, ddr_mode}, {31'd0, mode});
    chk({tag, "_base"}, ddr_base, base);
    chk({tag, "_len"},  {23'd0, ddr_len}, len);
    repeat (dly) @(negedge clk);
    ddr_done = 1'b1;
    ddr_err  = e;
    @(negedge clk);
    ddr_done = 1'b0;
    ddr_err  = 4'd0;
  endtask

  initial begin
    rst = 1'b1; rd_req = 0; wr_req = 0; rd_base = 0; wr_base = 0;
    rd_total = 0; wr_total = 0; ddr_done = 0; ddr_err = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", {19'd0, ddr_req, ddr_mode, rd_busy, rd_done, rd_err, wr_busy, wr_done, wr_err, err, ddr_len[0]}, 32'd0);
    chk("reset_len_base", {23'd0, ddr_len} | ddr_base, 32'd0);

    // 1: read 600 beats from 0 -> 256@0, 256@0x400, 88@0x800
    rd_req = 1; rd_base = 32'h0; rd_total = 24'd600;
    @(negedge clk);
    rd_req = 0;
    chk("t1_busy", {31'd0, rd_busy}, 32'd1);
    chk("t1_noreq_yet", {31'd0, ddr_req}, 32'd0);
    @(negedge clk);
    chk("t1_latency", {31'd0, ddr_req}, 32'd1);
    expect_burst("t1_b0", 1'b0, 32'h000, 256, 4'd0, 2);
    chk("t1_gap", {31'd0, ddr_req}, 32'd0);
    chk("t1_notdone", {30'd0, rd_done, rd_busy}, 32'd1);
    expect_burst("t1_b1", 1'b0, 32'h400, 256, 4'd0, 1);
    expect_burst("t1_b2", 1'b0, 32'h800, 88, 4'd0, 3);
    chk("t1_done", {29'd0, rd_done, rd_err, rd_busy}, 32'b100);

    // 2: write 100 beats from 0xF80 -> 32@0xF80, 68@0x1000
    wr_req = 1; wr_base = 32'hF80; wr_total = 24'd100;
    @(negedge clk);
    wr_req = 0;
    expect_burst("t2_b0", 1'b1, 32'hF80, 32, 4'd0, 1);
    expect_burst("t2_b1", 1'b1, 32'h1000, 68, 4'd0, 1);
    chk("t2_done", {29'd0, wr_done, wr_err, wr_busy}, 32'b100);

    // 3: simultaneous read/write of 512 beats -> R,W,R,W
    rd_req = 1; rd_base = 32'h0; rd_total = 24'd512;
    wr_req = 1; wr_base = 32'h0; wr_total = 24'd512;
    @(negedge clk);
    rd_req = 0; wr_req = 0;
    expect_burst("t3_r0", 1'b0, 32'h000, 256, 4'd0, 1);
    expect_burst("t3_w0", 1'b1, 32'h000, 256, 4'd0, 1);
    expect_burst("t3_r1", 1'b0, 32'h400, 256, 4'd0, 1);
    chk("t3_rd_done", {31'd0, rd_done}, 32'd1);
    expect_burst("t3_w1", 1'b1, 32'h400, 256, 4'd0, 1);
    chk("t3_wr_done", {31'd0, wr_done}, 32'd1);
    @(negedge clk);
    chk("t3_rd_cnt", n_rd_done, 2);
    chk("t3_wr_cnt", n_wr_done, 2);

    // 4: zero-length read completes with no burst
    rec_req = n_req;
    rd_req = 1; rd_base = 32'h40; rd_total = 24'd0;
    @(negedge clk);
    rd_req = 0;
    chk("t4_done", {29'd0, rd_done, rd_err, rd_busy}, 32'b100);
    repeat (5) @(negedge clk);
    chk("t4_noburst", n_req, rec_req);

    // 5: read aborted by DMA error while write proceeds; extra rd_req while busy ignored
    rd_req = 1; rd_base = 32'h0; rd_total = 24'd600;
    wr_req = 1; wr_base = 32'h2000; wr_total = 24'd64;
    @(negedge clk);
    wr_req = 0; rd_total = 24'd0;
    rec_rd = n_rd_done;
    @(negedge clk);
    rd_req = 0;
    expect_burst("t5_r0", 1'b0, 32'h000, 256, 4'b0100, 1);
    chk("t5_abort", {29'd0, rd_done, rd_err, rd_busy}, 32'b110);
    chk("t5_err", {28'd0, err}, 32'h5);
    expect_burst("t5_w0", 1'b1, 32'h2000, 64, 4'd0, 1);
    chk("t5_wr_done", {29'd0, wr_done, wr_err, wr_busy}, 32'b100);
    rec_req = n_req;
    repeat (4) @(negedge clk);
    chk("t5_rd_cnt", n_rd_done, rec_rd + 1);
    chk("t5_noburst", n_req, rec_req);

    // 6: reset during a burst, stale ddr_done, fresh command, misaligned command
    rd_req = 1; rd_base = 32'h0; rd_total = 24'd600;
    @(negedge clk);
    rd_req = 0;
    wait_req("t6_pre");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_outs", {19'd0, ddr_req, ddr_mode, rd_busy, rd_done, rd_err, wr_busy, wr_done, wr_err, err, ddr_len[0]}, 32'd0);
    chk("t6_rst_len_base", {23'd0, ddr_len} | ddr_base, 32'd0);
    rec_rd = n_rd_done; rec_wr = n_wr_done; rec_req = n_req;
    ddr_done = 1'b1; ddr_err = 4'b0010;
    @(negedge clk);
    ddr_done = 1'b0; ddr_err = 4'd0;
    repeat (3) @(negedge clk);
    chk("t6_stale_done", n_rd_done + n_wr_done + n_req, rec_rd + rec_wr + rec_req);
    chk("t6_stale_err", {28'd0, err}, 32'd0);
    rd_req = 1; rd_base = 32'h100; rd_total = 24'd4;
    @(negedge clk);
    rd_req = 0;
    expect_burst("t6_f", 1'b0, 32'h100, 4, 4'd0, 1);
    chk("t6_f_done", {29'd0, rd_done, rd_err, rd_busy}, 32'b100);
    rd_req = 1; rd_base = 32'h2; rd_total = 24'd8;
    @(negedge clk);
    rd_req = 0;
    chk("t6_mis_done", {29'd0, rd_done, rd_err, rd_busy}, 32'b110);
    chk("t6_mis_err", {28'd0, err}, 32'h3);
    rec_req = n_req;
    repeat (4) @(negedge clk);
    chk("t6_mis_noburst", n_req, rec_req);

    chk("no_back_to_back_req", consec, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
